// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Each grant lasts up to MAX_BURST beats; writes are suppressed while the FIFO is full.
module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DATA_W    = 128,
   parameter int MAX_BURST = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        grant,
   input  logic                    fifo_full,
   output logic                    fifo_wren,
   output logic [DATA_W-1:0]       fifo_wrdata,
   output logic                    busy,
   output logic [15:0]             stall_cnt
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_nxt;
   logic [BC_W-1:0]  beat_cnt, beat_nxt;
   logic [IDX_W-1:0] pick;
   logic             owner_vld;
   logic             accept;
   logic             stall;

   // Walk downward so the candidate closest to rr_ptr is the last one written.
   always_comb begin
      logic [IDX_W:0] j;
      pick = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (j >= (IDX_W+1)'(N_REQ)) j = j - (IDX_W+1)'(N_REQ);
         if (req_valid[j[IDX_W-1:0]]) pick = j[IDX_W-1:0];
      end
   end

   assign owner_vld = req_valid[owner];
   assign accept    = (state == GRANT) & owner_vld & ~fifo_full;
   assign stall     = (state == GRANT) & owner_vld & fifo_full;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      rr_nxt    = rr_ptr;
      beat_nxt  = beat_cnt;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               owner_nxt = pick;
               beat_nxt  = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (accept) beat_nxt = beat_cnt + 1'b1;
            if (!owner_vld || (accept && beat_cnt == BC_W'(MAX_BURST - 1))) begin
               state_nxt = IDLE;
               rr_nxt    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_nxt;
         beat_cnt <= beat_nxt;
         if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign busy        = (state == GRANT);
   assign grant       = busy   ? (N_REQ'(1) << owner) : '0;
   assign req_ready   = accept ? (N_REQ'(1) << owner) : '0;
   assign fifo_wren   = accept;
   assign fifo_wrdata = accept ? req_data[int'(owner)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a per-producer queue model.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 128;
   localparam int MB = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    grant;
   logic             fifo_full;
   logic             fifo_wren;
   logic [DW-1:0]    fifo_wrdata;
   logic             busy;
   logic [15:0]      stall_cnt;

   fifo_wr_arbiter #(.N_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .grant(grant), .fifo_full(fifo_full),
      .fifo_wren(fifo_wren), .fifo_wrdata(fifo_wrdata), .busy(busy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Pending beats per producer; the front is what the producer currently offers.
   logic [DW-1:0] q [NR][$];

   int m_busy, m_owner, m_rr, m_beats, m_stall;
   int checks = 0, errors = 0;
   logic [NR-1:0] last_grant;
   logic          last_wren;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]          = (q[i].size() != 0);
         req_data[i*DW +: DW]  = (q[i].size() != 0) ? q[i][0] : '0;
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_stall = 0;
      for (int i = 0; i < NR; i++) q[i].delete();
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock: check outputs at negedge, advance model at posedge, re-drive at +1.
   task automatic cycle();
      logic v, acc;
      logic [NR-1:0] eg, er;
      logic [DW-1:0] ed;
      int own;
      @(negedge clk);
      v   = (m_busy != 0) && (q[m_owner].size() != 0);
      acc = v && !fifo_full;
      eg = '0; er = '0; ed = '0;
      if (m_busy != 0) eg[m_owner] = 1'b1;
      if (acc) begin er[m_owner] = 1'b1; ed = q[m_owner][0]; end
      chk("grant", grant, eg);
      chk("busy", busy, m_busy != 0);
      chk("req_ready", req_ready, er);
      chk("wren", fifo_wren, acc);
      chk("wrdata", fifo_wrdata, ed);
      chk("stall_cnt", stall_cnt, m_stall);
      last_grant = grant;
      last_wren  = fifo_wren;
      @(posedge clk);
      own = m_owner;
      if (m_busy == 0) begin
         for (int k = NR - 1; k >= 0; k--)
            if (q[(m_rr + k) % NR].size() != 0) begin
               m_owner = (m_rr + k) % NR;
               m_busy  = 1;
               m_beats = 0;
            end
      end else if (!v) begin
         m_busy = 0; m_rr = (own + 1) % NR;
      end else if (fifo_full) begin
         if (m_stall < 65535) m_stall++;
      end else begin
         m_beats++;
         if (m_beats == MB) begin m_busy = 0; m_rr = (own + 1) % NR; end
      end
      if (acc) void'(q[own].pop_front());
      #1 drive();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      fifo_full = 1'b0;
      model_reset();
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cnt;
      logic [15:0] s0;
      reset = 1'b0;
      fifo_full = 1'b0;
      model_reset();
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_wren", fifo_wren, 0);
      chk("rst_wrdata", fifo_wrdata, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single producer, three beats; leaves the pointer at 3.
      q[2].push_back(128'hA); q[2].push_back(128'hB); q[2].push_back(128'hC);
      drive();
      cnt = 0;
      repeat (6) begin cycle(); if (last_wren) cnt++; end
      chk("single_writes", cnt, 3);

      // Wrap fairness: producer 3 ahead of producer 0.
      q[0].push_back(rnd128()); q[3].push_back(rnd128());
      drive();
      cycle();
      cycle();
      chk("fair_first", last_grant, 4'b1000);
      repeat (6) cycle();

      // All producers continuously valid from pointer 0.
      do_reset();
      for (int i = 0; i < NR; i++) repeat (8) q[i].push_back(rnd128());
      drive();
      cycle();
      cnt = 0;
      repeat (20) begin cycle(); if (last_wren) cnt++; end
      chk("burst_writes", cnt, 16);
      repeat (25) cycle();

      // Full stall in the middle of a producer-1 burst.
      repeat (4) q[1].push_back(rnd128());
      drive();
      cycle();
      cycle();
      s0 = stall_cnt;
      fifo_full = 1'b1;
      repeat (5) cycle();
      chk("stall_delta", stall_cnt - s0, 5);
      fifo_full = 1'b0;
      repeat (8) cycle();

      // Reset during beat 2 of a producer-2 burst.
      repeat (4) q[2].push_back(rnd128());
      drive();
      cycle();
      cycle();
      #3 reset = 1'b0;
      #1;
      chk("arst_grant", grant, 0);
      chk("arst_busy", busy, 0);
      chk("arst_wren", fifo_wren, 0);
      chk("arst_ready", req_ready, 0);
      chk("arst_wrdata", fifo_wrdata, 0);
      chk("arst_stall", stall_cnt, 0);
      model_reset();
      drive();
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      q[0].push_back(rnd128()); q[2].push_back(rnd128());
      drive();
      cycle();
      cycle();
      chk("rst_first", last_grant, 4'b0001);
      repeat (10) cycle();

      // Random traffic and backpressure.
      repeat (1500) begin
         for (int i = 0; i < NR; i++)
            if ($urandom_range(0, 5) == 0 && q[i].size() < 6) q[i].push_back(rnd128());
         fifo_full = ($urandom_range(0, 3) == 0);
         drive();
         cycle();
      end
      fifo_full = 1'b0;
      repeat (60) cycle();

      // Stall counter saturation.
      q[3].push_back(rnd128());
      fifo_full = 1'b1;
      drive();
      repeat (65545) cycle();
      chk("stall_sat", stall_cnt, 16'hFFFF);
      repeat (5) cycle();
      chk("stall_hold", stall_cnt, 16'hFFFF);
      fifo_full = 1'b0;
      repeat (4) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
